npu_tile_sequencer: RTL and testbench

//  Sequences one NPU core MAC array over a tiled conv/matmul job: M output tiles x K reduction steps.

---
 rtl/npu_tile_sequencer_if.sv | 42 ++++
 rtl/npu_tile_sequencer.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_npu_tile_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_tile_sequencer_if.sv
// ----------------------------------------------------------------------------
// npu_tile_sequencer_if
//  Datapath-facing bundle of the NPU tile sequencer: the paired weight /
//  activation SRAM read channel, the MAC array strobes and the output-buffer
//  write channel. The sequencer uses the master modport; the core datapath
//  and SRAM ports use the slave modport.
// ----------------------------------------------------------------------------
interface npu_tile_sequencer_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] w_addr;
    logic [15:0] a_addr;
    logic        mac_en;
    logic        mac_clear;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] o_addr;

    modport master (
        output rd_valid,
        output w_addr,
        output a_addr,
        output mac_en,
        output mac_clear,
        output wr_valid,
        output o_addr,
        input  rd_ready,
        input  wr_ready
    );

    modport slave (
        input  rd_valid,
        input  w_addr,
        input  a_addr,
        input  mac_en,
        input  mac_clear,
        input  wr_valid,
        input  o_addr,
        output rd_ready,
        output wr_ready
    );
endinterface

// File: rtl/npu_tile_sequencer.sv
// ----------------------------------------------------------------------------
// npu_tile_sequencer
//  Walks one MAC array through a tiled job of M output tiles x K reduction
//  steps: issues paired weight/activation read beats, replays each accepted
//  beat RD_LAT cycles later as the MAC strobe, waits RD_LAT+MAC_LAT cycles
//  for the pipeline to drain, then writes the tile result.
//
//  Optional feature: define NPU_SEQ_PERF_CNT_EN to add perf_stall_o, a
//  saturating count of handshake stall cycles, cleared on each accepted start.
// ----------------------------------------------------------------------------
module npu_tile_sequencer #(
    parameter int CNT_W   = 16,
    parameter int RD_LAT  = 2,
    parameter int MAC_LAT = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [CNT_W-1:0]      num_m_i,
    input  logic [CNT_W-1:0]      num_k_i,
    input  logic [15:0]           w_base_i,
    input  logic [15:0]           a_base_i,
    input  logic [14:0]           o_base_i,
    npu_tile_sequencer_if.master  bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            err_o
`ifdef NPU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_o
`endif
);

    localparam int                DRAIN_CYC  = RD_LAT + MAC_LAT;
    localparam int                DRN_W      = $clog2(DRAIN_CYC + 1);
    localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);
    localparam logic [DRN_W-1:0]  DRN_ZERO   = DRN_W'(0);
    localparam logic [DRN_W-1:0]  DRN_ONE    = DRN_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d, state_nxt_s;
    logic [CNT_W-1:0]   num_m_q, num_m_d;
    logic [CNT_W-1:0]   num_k_q, num_k_d;
    logic [15:0]        w_base_q, w_base_d;
    logic [CNT_W-1:0]   k_cnt_q, k_cnt_d;
    logic [CNT_W-1:0]   m_cnt_q, m_cnt_d;
    logic [DRN_W-1:0]   drn_cnt_q, drn_cnt_d;
    logic [15:0]        w_addr_q, w_addr_d;
    logic [15:0]        a_addr_q, a_addr_d;
    logic [14:0]        o_addr_q, o_addr_d;
    logic [RD_LAT-1:0]  en_dl_q, en_dl_d;
    logic [RD_LAT-1:0]  clr_dl_q, clr_dl_d;
    logic               rd_valid_q, rd_valid_d;
    logic               wr_valid_q, wr_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d, err_nxt_s;

    logic               beat_s;
    logic               wr_acc_s;
    logic               zero_job_s;
    logic               last_k_s;
    logic               last_m_s;
    logic               start_acc_s;

    assign beat_s      = rd_valid_q & bus.rd_ready;
    assign wr_acc_s    = wr_valid_q & bus.wr_ready;
    assign zero_job_s  = (num_m_i == CNT_ZERO) || (num_k_i == CNT_ZERO);
    assign last_k_s    = (k_cnt_q == (num_k_q - CNT_ONE));
    assign last_m_s    = (m_cnt_q == (num_m_q - CNT_ONE));
    assign start_acc_s = (state_q == ST_IDLE) && start_i && !abort_i;

    // Next-state, pointer/counter and registered-output computation.
    always_comb begin
        state_nxt_s = state_q;
        err_nxt_s   = err_q;
        num_m_d     = num_m_q;
        num_k_d     = num_k_q;
        w_base_d    = w_base_q;
        k_cnt_d     = k_cnt_q;
        m_cnt_d     = m_cnt_q;
        drn_cnt_d   = drn_cnt_q;
        w_addr_d    = w_addr_q;
        a_addr_d    = a_addr_q;
        o_addr_d    = o_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    num_m_d  = num_m_i;
                    num_k_d  = num_k_i;
                    w_base_d = w_base_i;
                    k_cnt_d  = CNT_ZERO;
                    m_cnt_d  = CNT_ZERO;
                    w_addr_d = w_base_i;
                    a_addr_d = a_base_i;
                    o_addr_d = o_base_i;
                    if (zero_job_s) begin
                        err_nxt_s   = 2'b01;
                        state_nxt_s = ST_DONE;
                    end else begin
                        err_nxt_s   = 2'b00;
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start_i) begin
                    err_nxt_s[1] = 1'b1;
                end else begin
                    err_nxt_s = err_q;
                end
                if (beat_s) begin
                    // Activation pointer runs across tiles: m*K + k without a multiplier.
                    k_cnt_d  = k_cnt_q + CNT_ONE;
                    w_addr_d = w_addr_q + 16'd1;
                    a_addr_d = a_addr_q + 16'd1;
                    if (last_k_s) begin
                        drn_cnt_d   = DRN_ZERO;
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (start_i) begin
                    err_nxt_s[1] = 1'b1;
                end else begin
                    err_nxt_s = err_q;
                end
                if (drn_cnt_q == DRAIN_LAST) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    drn_cnt_d   = drn_cnt_q + DRN_ONE;
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_WRITE: begin
                if (start_i) begin
                    err_nxt_s[1] = 1'b1;
                end else begin
                    err_nxt_s = err_q;
                end
                if (wr_acc_s) begin
                    if (last_m_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        m_cnt_d     = m_cnt_q + CNT_ONE;
                        o_addr_d    = o_addr_q + 15'd1;
                        k_cnt_d     = CNT_ZERO;
                        w_addr_d    = w_base_q;
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a start in the same cycle.
        if (abort_i) begin
            state_d = ST_IDLE;
            err_d   = err_q;
        end else begin
            state_d = state_nxt_s;
            err_d   = err_nxt_s;
        end

        rd_valid_d = (state_d == ST_RUN);
        wr_valid_d = (state_d == ST_WRITE);
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_WRITE);
        done_d     = (state_d == ST_DONE);
    end

    // Read-data alignment delay line: accepted beat emerges RD_LAT cycles later as the MAC strobe.
    always_comb begin
        en_dl_d  = en_dl_q;
        clr_dl_d = clr_dl_q;
        if (abort_i) begin
            en_dl_d  = {RD_LAT{1'b0}};
            clr_dl_d = {RD_LAT{1'b0}};
        end else begin
            en_dl_d[0]  = beat_s;
            clr_dl_d[0] = beat_s && (k_cnt_q == CNT_ZERO);
            for (int i = 1; i < RD_LAT; i++) begin
                en_dl_d[i]  = en_dl_q[i-1];
                clr_dl_d[i] = clr_dl_q[i-1];
            end
        end
    end

    // State, pointers, delay line and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            num_m_q    <= CNT_ZERO;
            num_k_q    <= CNT_ZERO;
            w_base_q   <= 16'd0;
            k_cnt_q    <= CNT_ZERO;
            m_cnt_q    <= CNT_ZERO;
            drn_cnt_q  <= DRN_ZERO;
            w_addr_q   <= 16'd0;
            a_addr_q   <= 16'd0;
            o_addr_q   <= 15'd0;
            en_dl_q    <= {RD_LAT{1'b0}};
            clr_dl_q   <= {RD_LAT{1'b0}};
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            num_m_q    <= num_m_d;
            num_k_q    <= num_k_d;
            w_base_q   <= w_base_d;
            k_cnt_q    <= k_cnt_d;
            m_cnt_q    <= m_cnt_d;
            drn_cnt_q  <= drn_cnt_d;
            w_addr_q   <= w_addr_d;
            a_addr_q   <= a_addr_d;
            o_addr_q   <= o_addr_d;
            en_dl_q    <= en_dl_d;
            clr_dl_q   <= clr_dl_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.rd_valid  = rd_valid_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.a_addr    = a_addr_q;
    assign bus.mac_en    = en_dl_q[RD_LAT-1];
    assign bus.mac_clear = clr_dl_q[RD_LAT-1];
    assign bus.wr_valid  = wr_valid_q;
    assign bus.o_addr    = o_addr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

`ifdef NPU_SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;
    logic        stall_s;

    assign stall_s = (rd_valid_q & ~bus.rd_ready) | (wr_valid_q & ~bus.wr_ready);

    // Saturating stall-cycle counter, restarted by each accepted start.
    always_comb begin
        perf_d = perf_q;
        if (start_acc_s) begin
            perf_d = 32'd0;
        end else if (stall_s && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end else begin
            perf_d = perf_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_o = perf_q;
`else
    logic unused_start_acc_s;
    assign unused_start_acc_s = start_acc_s;
`endif

endmodule

// File: tb/tb_npu_tile_sequencer.sv
// ----------------------------------------------------------------------------
// tb_npu_tile_sequencer
//  Scoreboard bench: each job pushes its expected read beats and writes;
//  a negedge monitor pops and compares them as the DUT produces them, and
//  derives the expected MAC strobes from the accepted beats.
// ----------------------------------------------------------------------------
module tb_npu_tile_sequencer;

    localparam int RD_LAT  = 2;
    localparam int MAC_LAT = 3;

    typedef struct {
        logic [15:0] w;
        logic [15:0] a;
        int          k;
    } rd_exp_t;

    typedef struct {
        logic clr;
        int   cyc;
    } mac_exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        abort_i;
    logic [15:0] num_m_i;
    logic [15:0] num_k_i;
    logic [15:0] w_base_i;
    logic [15:0] a_base_i;
    logic [14:0] o_base_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  err_o;
`ifdef NPU_SEQ_PERF_CNT_EN
    logic [31:0] perf_stall_o;
`endif

    npu_tile_sequencer_if bus ();

    npu_tile_sequencer #(
        .CNT_W   (16),
        .RD_LAT  (RD_LAT),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .abort_i  (abort_i),
        .num_m_i  (num_m_i),
        .num_k_i  (num_k_i),
        .w_base_i (w_base_i),
        .a_base_i (a_base_i),
        .o_base_i (o_base_i),
        .bus      (bus),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o)
`ifdef NPU_SEQ_PERF_CNT_EN
        ,
        .perf_stall_o (perf_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    rd_exp_t     exp_rd[$];
    mac_exp_t    exp_mac[$];
    logic [14:0] exp_wr[$];

    int rd_beats = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wr_cnt = 0;
    int wr_valid_cycles = 0;
    int start_cyc = 0;

    logic        rd_stall_prev = 1'b0;
    logic        wr_stall_prev = 1'b0;
    logic [15:0] prev_w;
    logic [15:0] prev_a;
    logic [14:0] prev_o;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk_i) begin
        rd_exp_t  re;
        mac_exp_t me;
        logic [14:0] eo;
        if (bus.rd_valid && bus.rd_ready) begin
            rd_beats++;
            if (exp_rd.size() == 0) begin
                check_eq("rd_unexpected", 32'd1, 32'd0);
            end else begin
                re = exp_rd.pop_front();
                check_eq("w_addr", {16'd0, bus.w_addr}, {16'd0, re.w});
                check_eq("a_addr", {16'd0, bus.a_addr}, {16'd0, re.a});
                me.clr = (re.k == 0);
                me.cyc = cyc + RD_LAT;
                exp_mac.push_back(me);
            end
        end
        if (bus.rd_valid && !bus.rd_ready) begin
            if (rd_stall_prev) begin
                check_eq("w_addr_stall", {16'd0, bus.w_addr}, {16'd0, prev_w});
                check_eq("a_addr_stall", {16'd0, bus.a_addr}, {16'd0, prev_a});
            end
            rd_stall_prev = 1'b1;
            prev_w = bus.w_addr;
            prev_a = bus.a_addr;
        end else begin
            rd_stall_prev = 1'b0;
        end
        if (bus.mac_en) begin
            if (exp_mac.size() == 0) begin
                check_eq("mac_unexpected", 32'd1, 32'd0);
            end else begin
                me = exp_mac.pop_front();
                check_eq("mac_clear", {31'd0, bus.mac_clear}, {31'd0, me.clr});
                check_eq("mac_cycle", cyc, me.cyc);
            end
        end
        if (bus.mac_clear && !bus.mac_en) check_eq("clear_without_en", 32'd1, 32'd0);
        if (bus.wr_valid) begin
            wr_valid_cycles++;
            check_eq("rd_during_wr", {31'd0, bus.rd_valid}, 32'd0);
            if (bus.wr_ready) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    check_eq("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    eo = exp_wr.pop_front();
                    check_eq("o_addr", {17'd0, bus.o_addr}, {17'd0, eo});
                end
                wr_stall_prev = 1'b0;
            end else begin
                if (wr_stall_prev) check_eq("o_addr_stall", {17'd0, bus.o_addr}, {17'd0, prev_o});
                wr_stall_prev = 1'b1;
                prev_o = bus.o_addr;
            end
        end else begin
            wr_stall_prev = 1'b0;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            check_eq("busy_at_done", {31'd0, busy_o}, 32'd0);
        end
    end

    // Push expectations for a job and pulse start for one cycle
    task automatic run_job(input int m, input int k, input logic [15:0] wb,
                           input logic [15:0] ab, input logic [14:0] ob, input bit push_wr);
        rd_exp_t re;
        for (int mi = 0; mi < m; mi++) begin
            for (int ki = 0; ki < k; ki++) begin
                re.w = wb + 16'(ki);
                re.a = ab + 16'(mi * k + ki);
                re.k = ki;
                exp_rd.push_back(re);
            end
            if (push_wr) exp_wr.push_back(ob + 15'(mi));
        end
        num_m_i  = 16'(m);
        num_k_i  = 16'(k);
        w_base_i = wb;
        a_base_i = ab;
        o_base_i = ob;
        start_i  = 1'b1;
        start_cyc = cyc;
        @(posedge clk_i); #1;
        start_i  = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done_cnt > base) break;
            @(posedge clk_i); #1;
        end
        if (i == budget) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic job_and_check(input int m, input int k, input logic [15:0] wb,
                                 input logic [15:0] ab, input logic [14:0] ob, input int lat);
        int base;
        base = done_cnt;
        run_job(m, k, wb, ab, ob, 1'b1);
        check_eq("busy_running", {31'd0, busy_o}, 32'd1);
        wait_done(base, 400);
        check_eq("latency", done_cyc - start_cyc, lat);
        check_eq("done_once", done_cnt - base, 32'd1);
        check_eq("err_ok", {30'd0, err_o}, 32'd0);
    endtask

    initial begin
        int base;
        int base_wv;
        int rb;
        int i;
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        num_m_i = 16'd0; num_k_i = 16'd0;
        w_base_i = 16'd0; a_base_i = 16'd0; o_base_i = 15'd0;
        bus.rd_ready = 1'b1; bus.wr_ready = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check_eq("rst_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
        check_eq("rst_mac_en", {31'd0, bus.mac_en}, 32'd0);
        check_eq("rst_mac_clear", {31'd0, bus.mac_clear}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);
        check_eq("rst_err", {30'd0, err_o}, 32'd0);
        check_eq("rst_addr", {bus.w_addr, bus.a_addr} | {17'd0, bus.o_addr}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Single tile, K=4: done 11 cycles after start
        job_and_check(1, 4, 16'h0010, 16'h0020, 15'h0005, 11);
        repeat (2) @(posedge clk_i); #1;

        // Three tiles, K=2: contiguous activations, repeating weights
        job_and_check(3, 2, 16'h0000, 16'h0100, 15'h0000, 25);
        repeat (2) @(posedge clk_i); #1;

        // Read stall of 3 cycles mid-tile and write stall of 5 cycles
        bus.wr_ready = 1'b0;
        rb = rd_beats;
        fork
            job_and_check(2, 4, 16'h0200, 16'h0300, 15'h0040, 2 * 10 + 1 + 3 + 5);
            begin
                for (i = 0; i < 200 && rd_beats < rb + 2; i++) begin
                    @(posedge clk_i); #1;
                end
                bus.rd_ready = 1'b0;
                repeat (3) @(posedge clk_i);
                #1;
                bus.rd_ready = 1'b1;
            end
            begin
                for (i = 0; i < 200 && !bus.wr_valid; i++) begin
                    @(posedge clk_i); #1;
                end
                repeat (5) @(posedge clk_i);
                #1;
                bus.wr_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk_i); #1;

        // Zero-size job: error, one-cycle done, no reads
        base = done_cnt;
        rb = rd_beats;
        num_m_i = 16'd2; num_k_i = 16'd0;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check_eq("zero_err", {30'd0, err_o}, 32'd1);
        check_eq("zero_busy", {31'd0, busy_o}, 32'd0);
        check_eq("zero_done", {31'd0, done_o}, 32'd1);
        @(posedge clk_i); #1;
        check_eq("zero_done_pulse", {31'd0, done_o}, 32'd0);
        check_eq("zero_done_cnt", done_cnt - base, 32'd1);
        check_eq("zero_no_reads", rd_beats - rb, 32'd0);

        // Start while busy is ignored and flagged; weight address wraps
        base = done_cnt;
        run_job(1, 2, 16'hFFFF, 16'hFFFE, 15'h7FFF, 1'b1);
        repeat (2) @(posedge clk_i);
        #1;
        num_m_i = 16'd9; num_k_i = 16'd5; w_base_i = 16'h1234;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check_eq("busy_start_err", {30'd0, err_o}, 32'd2);
        wait_done(base, 200);
        check_eq("busy_start_latency", done_cyc - start_cyc, 32'd9);
        check_eq("busy_start_err_kept", {30'd0, err_o}, 32'd2);
        repeat (2) @(posedge clk_i); #1;

        // Next accepted start clears the sticky error
        job_and_check(1, 1, 16'h0050, 16'h0060, 15'h0011, 8);
        repeat (2) @(posedge clk_i); #1;

        // Abort during DRAIN: idle next cycle, no write, no done
        base = done_cnt;
        base_wv = wr_valid_cycles;
        run_job(1, 2, 16'h0040, 16'h0050, 15'h0009, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("drain_busy", {31'd0, busy_o}, 32'd1);
        check_eq("drain_no_rd", {31'd0, bus.rd_valid}, 32'd0);
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        check_eq("abort_busy", {31'd0, busy_o}, 32'd0);
        check_eq("abort_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
        repeat (12) @(posedge clk_i);
        #1;
        check_eq("abort_no_done", done_cnt - base, 32'd0);
        check_eq("abort_no_write", wr_valid_cycles - base_wv, 32'd0);

        check_eq("rd_queue_empty", exp_rd.size(), 32'd0);
        check_eq("mac_queue_empty", exp_mac.size(), 32'd0);
        check_eq("wr_queue_empty", exp_wr.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
